// File: rtl/qt_pkg.sv
// rtl/qt_pkg.sv - shared Pauli encodings, FSM state enum and index-width helper
package qt_pkg;

  // Net correction on one qubit; bit0 = X, bit1 = Z, global phase dropped
  typedef enum logic [1:0] {
    P_I  = 2'b00,
    P_X  = 2'b01,
    P_Z  = 2'b10,
    P_XZ = 2'b11
  } pauli_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } fsm_state_t;

  // A single tracked qubit still needs a one-bit index
  function automatic int qidx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pauli_frame_corrector_if.sv
// rtl/pauli_frame_corrector_if.sv - measurement-in and correction-out handshakes
interface pauli_frame_corrector_if #(
  parameter int QIDX_W = 2
);
  import qt_pkg::*;

  logic              meas_valid;
  logic              meas_ready;
  logic [QIDX_W-1:0] meas_qidx;
  logic [1:0]        meas_bits;

  logic              out_valid;
  logic              out_ready;
  logic [QIDX_W-1:0] out_qidx;
  pauli_t            out_pauli;

  modport master (
    output meas_valid, meas_qidx, meas_bits, out_ready,
    input  meas_ready, out_valid, out_qidx, out_pauli
  );

  modport slave (
    input  meas_valid, meas_qidx, meas_bits, out_ready,
    output meas_ready, out_valid, out_qidx, out_pauli
  );

endinterface

// File: rtl/qt_frame_bank.sv
// rtl/qt_frame_bank.sv - per-qubit X/Z frame storage with XOR-update and clear ports
module qt_frame_bank
  import qt_pkg::*;
#(
  parameter int NUM_QUBITS = 4,
  parameter int QIDX_W     = qidx_width(NUM_QUBITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              xor_en,
  input  logic [QIDX_W-1:0] xor_idx,
  input  logic [1:0]        xor_bits,
  input  logic              clr_en,
  input  logic [QIDX_W-1:0] clr_idx,
  input  logic [QIDX_W-1:0] rd_idx,
  output pauli_t            rd_bits
);

  pauli_t frame [NUM_QUBITS];

  // Update each entry by matching its own index, so indices past NUM_QUBITS touch nothing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_QUBITS; i++) frame[i] <= P_I;
    end else begin
      for (int i = 0; i < NUM_QUBITS; i++) begin
        if (clr_en && int'(clr_idx) == i)
          frame[i] <= P_I;
        else if (xor_en && int'(xor_idx) == i)
          frame[i] <= pauli_t'(frame[i] ^ xor_bits);
      end
    end
  end

  // Read mux; an out-of-range index reads as identity
  always_comb begin
    rd_bits = P_I;
    for (int i = 0; i < NUM_QUBITS; i++) begin
      if (int'(rd_idx) == i) rd_bits = frame[i];
    end
  end

endmodule

// File: rtl/pauli_frame_corrector.sv
// rtl/pauli_frame_corrector.sv - accumulates teleportation corrections and flushes them per qubit
module pauli_frame_corrector
  import qt_pkg::*;
#(
  parameter int NUM_QUBITS    = 4,
  parameter int SKIP_IDENTITY = 1,
  parameter int CNT_W         = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pauli_frame_corrector_if.slave bus,
  input  logic                   flush_req,
  output logic                   flush_done,
  output logic [CNT_W-1:0]       corr_count,
  output logic                   idx_err
);

  localparam int QIDX_W = qidx_width(NUM_QUBITS);

  localparam logic [1:0] IDLE = 2'(S_IDLE);
  localparam logic [1:0] SCAN = 2'(S_SCAN);
  localparam logic [1:0] EMIT = 2'(S_EMIT);
  localparam logic [1:0] DONE = 2'(S_DONE);

  localparam logic [QIDX_W-1:0] LAST_IDX = QIDX_W'(NUM_QUBITS - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [QIDX_W-1:0] idx;
  logic [QIDX_W-1:0] idx_nxt;
  logic              meas_fire;
  logic              meas_in_range;
  logic              emit_fire;
  pauli_t            rd_bits;

  assign meas_fire     = bus.meas_valid && (state == IDLE);
  assign meas_in_range = int'(bus.meas_qidx) < NUM_QUBITS;
  assign emit_fire     = (state == EMIT) && bus.out_ready;

  qt_frame_bank #(
    .NUM_QUBITS (NUM_QUBITS),
    .QIDX_W     (QIDX_W)
  ) u_frame_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .xor_en   (meas_fire && meas_in_range),
    .xor_idx  (bus.meas_qidx),
    .xor_bits (bus.meas_bits),
    .clr_en   (emit_fire),
    .clr_idx  (idx),
    .rd_idx   (idx),
    .rd_bits  (rd_bits)
  );

  // Next-state: walk the frame one qubit per SCAN cycle, stalling in EMIT until accepted
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (flush_req) begin
          state_nxt = SCAN;
          idx_nxt   = '0;
        end
      end
      SCAN: begin
        if (rd_bits != P_I || SKIP_IDENTITY == 0)
          state_nxt = EMIT;
        else if (idx == LAST_IDX)
          state_nxt = DONE;
        else
          idx_nxt = idx + 1'b1;
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SCAN;
            idx_nxt   = idx + 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, scan index, saturating correction counter and sticky index error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      corr_count <= '0;
      idx_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (emit_fire && rd_bits != P_I && corr_count != {CNT_W{1'b1}})
        corr_count <= corr_count + 1'b1;
      if (meas_fire && !meas_in_range)
        idx_err <= 1'b1;
    end
  end

  assign bus.meas_ready = (state == IDLE);
  assign bus.out_valid  = (state == EMIT);
  assign bus.out_qidx   = (state == EMIT) ? idx : '0;
  assign bus.out_pauli  = (state == EMIT) ? rd_bits : P_I;
  assign flush_done     = (state == DONE);

endmodule

// File: tb/tb_pauli_frame_corrector.sv
// tb/tb_pauli_frame_corrector.sv - directed bench with queue-based frame model for two configurations
module tb_pauli_frame_corrector;
  import qt_pkg::*;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       meas_valid = 1'b0;
  logic [1:0] meas_qidx  = 2'd0;
  logic [1:0] meas_bits  = 2'd0;
  logic       out_ready  = 1'b0;
  logic       flush_req  = 1'b0;

  logic        a_done, b_done, a_err, b_err;
  logic [1:0]  a_cnt;
  logic [15:0] b_cnt;

  pauli_frame_corrector_if #(.QIDX_W(2)) a_bus ();
  pauli_frame_corrector_if #(.QIDX_W(2)) b_bus ();

  assign a_bus.meas_valid = meas_valid;
  assign a_bus.meas_qidx  = meas_qidx;
  assign a_bus.meas_bits  = meas_bits;
  assign a_bus.out_ready  = out_ready;
  assign b_bus.meas_valid = meas_valid;
  assign b_bus.meas_qidx  = meas_qidx;
  assign b_bus.meas_bits  = meas_bits;
  assign b_bus.out_ready  = out_ready;

  // A: four qubits, identity skipped, two-bit counter
  pauli_frame_corrector #(.NUM_QUBITS(4), .SKIP_IDENTITY(1), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_bus), .flush_req(flush_req),
    .flush_done(a_done), .corr_count(a_cnt), .idx_err(a_err)
  );

  // B: three qubits, every qubit emitted, wide counter
  pauli_frame_corrector #(.NUM_QUBITS(3), .SKIP_IDENTITY(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_bus), .flush_req(flush_req),
    .flush_done(b_done), .corr_count(b_cnt), .idx_err(b_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: frame contents, and while flushing the list of corrections still owed
  int m_frame [2][4];
  bit m_busy  [2];
  int m_t     [2];
  int m_e     [2];
  int m_cnt   [2];
  bit m_err   [2];
  int em_q    [2][4];
  int em_p    [2][4];
  int em_n    [2];
  int em_h    [2];

  int log_q[$];
  int log_p[$];
  int a_stall = 0, a_done_cnt = 0, a_lat = 0, a_last_lat = 0;

  function automatic int nq(input int k);   return (k == 0) ? 4 : 3; endfunction
  function automatic bit skip(input int k); return (k == 0); endfunction
  function automatic int cmax(input int k); return (k == 0) ? 3 : 65535; endfunction

  // Entry j of the owed list appears once qubits 0..q have each had a scan cycle
  function automatic bit exp_valid(input int k);
    if (!m_busy[k] || em_h[k] >= em_n[k]) return 1'b0;
    return m_t[k] == em_q[k][em_h[k]] + 2 + m_e[k];
  endfunction

  // Done follows N scan cycles plus every cycle spent offering a correction
  function automatic bit exp_done(input int k);
    return m_busy[k] && em_h[k] == em_n[k] && m_t[k] == nq(k) + 1 + m_e[k];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int q = 0; q < 4; q++) m_frame[k][q] = 0;
      m_busy[k] = 0; m_t[k] = 0; m_e[k] = 0; m_cnt[k] = 0; m_err[k] = 0;
      em_n[k] = 0; em_h[k] = 0;
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (m_busy[k]) begin
        if (exp_done(k)) begin
          m_busy[k] = 0;
        end else begin
          if (exp_valid(k)) begin
            if (out_ready) begin
              m_frame[k][em_q[k][em_h[k]]] = 0;
              if (em_p[k][em_h[k]] != 0 && m_cnt[k] < cmax(k)) m_cnt[k]++;
              em_h[k]++;
            end
            m_e[k]++;
          end
          m_t[k]++;
        end
      end else begin
        if (meas_valid) begin
          if (int'(meas_qidx) < nq(k)) m_frame[k][meas_qidx] ^= int'(meas_bits);
          else m_err[k] = 1;
        end
        if (flush_req) begin
          em_n[k] = 0; em_h[k] = 0;
          for (int q = 0; q < nq(k); q++) begin
            if (m_frame[k][q] != 0 || !skip(k)) begin
              em_q[k][em_n[k]] = q;
              em_p[k][em_n[k]] = m_frame[k][q];
              em_n[k]++;
            end
          end
          m_busy[k] = 1; m_t[k] = 1; m_e[k] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic ov, fd, mr, ie;
      int   oq, op, cnt, eq, ep;
      bit   ev;
      if (k == 0) begin
        ov = a_bus.out_valid; fd = a_done; mr = a_bus.meas_ready; ie = a_err;
        oq = int'(a_bus.out_qidx); op = int'(a_bus.out_pauli); cnt = int'(a_cnt);
      end else begin
        ov = b_bus.out_valid; fd = b_done; mr = b_bus.meas_ready; ie = b_err;
        oq = int'(b_bus.out_qidx); op = int'(b_bus.out_pauli); cnt = int'(b_cnt);
      end
      ev = exp_valid(k);
      eq = 0; ep = 0;
      if (ev) begin
        eq = em_q[k][em_h[k]];
        ep = em_p[k][em_h[k]];
      end
      chk($sformatf("dut%0d out_valid", k), int'(ov), int'(ev));
      chk($sformatf("dut%0d out_qidx", k), oq, eq);
      chk($sformatf("dut%0d out_pauli", k), op, ep);
      chk($sformatf("dut%0d flush_done", k), int'(fd), int'(exp_done(k)));
      chk($sformatf("dut%0d meas_ready", k), int'(mr), int'(!m_busy[k]));
      chk($sformatf("dut%0d corr_count", k), cnt, m_cnt[k]);
      chk($sformatf("dut%0d idx_err", k), int'(ie), int'(m_err[k]));
    end
    if (a_bus.out_valid && out_ready) begin
      log_q.push_back(int'(a_bus.out_qidx));
      log_p.push_back(int'(a_bus.out_pauli));
    end
    if (a_bus.out_valid && !out_ready) a_stall++;
    if (flush_req) a_lat = 0; else a_lat++;
    if (a_done) begin
      a_done_cnt++;
      a_last_lat = a_lat;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic meas(input int q, input int b);
    meas_valid = 1'b1; meas_qidx = 2'(q); meas_bits = 2'(b);
    cyc();
    meas_valid = 1'b0;
  endtask

  task automatic flush();
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_busy[0] || m_busy[1]) && n < 100) begin
      cyc();
      n++;
    end
    chk("flush finished in time", int'(m_busy[0] || m_busy[1]), 0);
  endtask

  initial begin
    int d;
    model_reset();
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk("reset corr_count", int'(a_cnt), 0);
    chk("reset idx_err", int'(a_err), 0);
    chk("meas_ready after reset", int'(a_bus.meas_ready), 1);

    // X then XZ on q2 leaves Z
    out_ready = 1'b1;
    meas(2, 1); meas(2, 3);
    flush(); wait_idle();
    chk("single emit count", log_q.size(), 1);
    chk("emit qidx q2", log_q[0], 2);
    chk("emit pauli Z", log_p[0], 2);
    chk("corr_count after one", int'(a_cnt), 1);

    // XZ twice cancels: identity-only flush
    meas(1, 3); meas(1, 3);
    flush(); wait_idle();
    chk("no emit for identity frame", log_q.size(), 1);
    chk("identity flush latency", a_last_lat, 5);
    chk("corr_count unchanged", int'(a_cnt), 1);
    chk("b idx_err clear", int'(b_err), 0);

    // Two corrections with downstream stalled three cycles; q3 is out of range for B
    out_ready = 1'b0;
    meas(0, 1); meas(3, 2);
    chk("b idx_err set", int'(b_err), 1);
    flush();
    meas(1, 3);
    cyc(); cyc(); cyc();
    out_ready = 1'b1;
    wait_idle();
    chk("stall cycles", a_stall, 3);
    chk("emit count after stall", log_q.size(), 3);
    chk("first emit q0", log_q[1], 0);
    chk("first emit X", log_p[1], 1);
    chk("second emit q3", log_q[2], 3);
    chk("second emit Z", log_p[2], 2);
    chk("corr_count three", int'(a_cnt), 3);

    // Frame must be empty now
    d = a_done_cnt;
    flush(); wait_idle();
    chk("frame cleared, no emit", log_q.size(), 3);
    chk("frame cleared latency", a_last_lat, 5);
    chk("one flush_done", a_done_cnt, d + 1);

    // Two more non-identity emits: A saturates, B keeps counting
    meas(0, 3); meas(1, 1);
    flush(); wait_idle();
    chk("emit count five", log_q.size(), 5);
    chk("third pauli XZ", log_p[3], 3);
    chk("fourth pauli X", log_p[4], 1);
    chk("a corr_count saturated", int'(a_cnt), 3);
    chk("b corr_count four", int'(b_cnt), 4);

    // Reset while A is offering q2
    meas(2, 1);
    out_ready = 1'b0;
    flush();
    cyc(); cyc(); cyc(); cyc();
    chk("offering before reset", int'(a_bus.out_valid), 1);
    d = a_done_cnt;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("out_valid drops on reset", int'(a_bus.out_valid), 0);
    chk("out_qidx on reset", int'(a_bus.out_qidx), 0);
    chk("corr_count on reset", int'(a_cnt), 0);
    cyc(); cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();
    chk("meas_ready after release", int'(a_bus.meas_ready), 1);
    cyc(); cyc();
    chk("no flush_done after reset", a_done_cnt, d);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pauli_frame_corrector.md
PAULI_FRAME_CORRECTOR -- requirements
Module: pauli_frame_corrector

Interface
REQ-001 Parameter NUM_QUBITS, default 4: number of Bob qubits tracked (>=1).
REQ-002 Parameter SKIP_IDENTITY, default 1: 1 = flush emits only non-identity corrections; 0 = flush emits every qubit.
REQ-003 Parameter CNT_W, default 16: correction counter width.
REQ-004 Derived QIDX_W = max(1, clog2(NUM_QUBITS)).
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 meas_valid  input  1  Alice measurement result offered.
REQ-008 meas_ready  output  1  block accepts measurement.
REQ-009 meas_qidx  input  QIDX_W  target Bob qubit index.
REQ-010 meas_bits  input  2  bit0 = X correction needed, bit1 = Z correction needed.
REQ-011 flush_req  input  1  single-cycle request to emit and clear the frame.
REQ-012 out_valid  output  1  correction offered.
REQ-013 out_ready  input  1  downstream accepts correction.
REQ-014 out_qidx  output  QIDX_W  qubit index of offered correction.
REQ-015 out_pauli  output  2  net Pauli: 00 I, 01 X, 10 Z, 11 XZ.
REQ-016 flush_done  output  1  one-cycle pulse at end of flush.
REQ-017 corr_count  output  CNT_W  running count of non-identity corrections emitted.
REQ-018 idx_err  output  1  sticky flag: out-of-range meas_qidx seen.

Function
REQ-019 Block SHALL hold a Pauli frame: one X bit and one Z bit per qubit.
REQ-020 Measurement accepted when meas_valid && meas_ready; frame[meas_qidx] SHALL be XORed with meas_bits on that edge (X·X = I, Z·Z = I; global phase ignored).
REQ-021 meas_qidx >= NUM_QUBITS SHALL be accepted and discarded, frame unchanged, idx_err set.
REQ-022 FSM states IDLE, SCAN, EMIT, DONE; meas_ready = 1 only in IDLE.
REQ-023 IDLE: flush_req SHALL move to SCAN with scan index 0; a measurement accepted in the same cycle SHALL be applied before scanning.
REQ-024 flush_req outside IDLE SHALL be ignored.
REQ-025 SCAN (one cycle per qubit): if frame[idx] non-zero or SKIP_IDENTITY = 0, go to EMIT; else if idx = NUM_QUBITS-1, go to DONE; else increment idx and stay in SCAN.
REQ-026 EMIT: out_valid = 1 with out_qidx = idx and out_pauli = frame[idx]; outputs SHALL remain stable until out_ready.
REQ-027 On EMIT handshake: clear frame[idx]; increment corr_count if out_pauli != 00; go to DONE if idx = NUM_QUBITS-1, else increment idx and go to SCAN.
REQ-028 corr_count SHALL saturate at 2^CNT_W-1, with no wrap.
REQ-029 DONE SHALL assert flush_done for exactly one cycle, then return to IDLE.
REQ-030 Flush of an all-identity frame with SKIP_IDENTITY = 1: no out_valid; flush_done SHALL pulse NUM_QUBITS+1 cycles after flush_req.
REQ-031 out_valid, flush_done SHALL be 0 outside EMIT and DONE respectively.

Reset
REQ-032 Asynchronous assertion of rst_n SHALL force IDLE, frame all zero, scan index 0, corr_count 0, idx_err 0, out_valid 0, flush_done 0, out_qidx 0, out_pauli 00.
REQ-033 After rst_n deassertion, meas_ready SHALL be 1 on the first clock edge.
REQ-034 Reset mid-flush SHALL abandon the flush with no flush_done.

Structure
REQ-035 Shared package qt_pkg SHALL hold pauli_t (I, X, Z, XZ encodings) and the FSM state enum.
REQ-036 Frame storage and XOR/clear ports SHALL be a sub-module qt_frame_bank (parameter NUM_QUBITS).

Verification
REQ-037 N=4: meas (q2, 01), then (q2, 11), then flush -> single emit q2 with pauli 10, corr_count 1, flush_done.
REQ-038 N=4: meas (q1, 11), then (q1, 11), then flush -> no out_valid; flush_done 5 cycles after flush_req; corr_count unchanged.
REQ-039 N=4: frame q0 = 01, q3 = 10, out_ready held 0 for 3 cycles -> q0/01 held stable; then q3/10 emitted; frame all zero after flush_done.
REQ-040 N=3: meas_qidx = 3 -> idx_err = 1, frame unchanged; meas_ready stays 0 during flush.
REQ-041 CNT_W=2: five non-identity emits -> corr_count saturates at 3.
REQ-042 rst_n pulsed during EMIT -> out_valid 0 immediately, no flush_done, meas_ready 1 after release.
